// File: rtl/edge_arb_pkg.sv
// Shared defaults and helpers for the edge event arbiter.
package edge_arb_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_ID_W = 2;

  // Value prev_level takes in reset, so a level already high at release is an edge.
  localparam logic RESET_LEVEL = 1'b0;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/edge_detect_cell.sv
// Per-channel rising-edge detector; rise is combinational (Mealy) against the registered previous level.
module edge_detect_cell
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_level <= RESET_LEVEL;
    else       prev_level <= level;
  end

  assign rise = level & ~prev_level;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches rising edges on N level inputs and issues them one at a time, round-robin, over valid/ready.
// Optional OVF_DETECT_EN adds a sticky overflow flag for edges merged into an already-pending event.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int ID_W = DEF_ID_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    level,
  output logic            ev_valid,
  output logic [ID_W-1:0] ev_id,
  input  logic            ev_ready,
  output logic [N-1:0]    pending
`ifdef OVF_DETECT_EN
  ,
  output logic            overflow
`endif
);

  logic [N-1:0]    rise;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            load;

  for (genvar i = 0; i < N; i++) begin : g_cell
    edge_detect_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Search upward from rr_ptr over registered pending only; this cycle's edges wait a cycle.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign load = (~ev_valid | ev_ready) & found;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++)
      grant[i] = load && (winner == ID_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      // Set beats clear: an edge on the issuing channel re-arms it.
      pending <= rise | (pending & ~grant);
      if (load) begin
        ev_valid <= 1'b1;
        ev_id    <= winner;
        rr_ptr   <= ID_W'(rr_next(int'(winner), N));
      end else if (!ev_valid || ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

`ifdef OVF_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             overflow <= 1'b0;
    else if (|(rise & pending & ~grant))   overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: per-cycle compare against a behavioural model plus literal checks.
module tb_edge_event_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    level = '0;
  logic            ev_ready = 1'b0;
  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic [N-1:0]    pending;
`ifdef OVF_DETECT_EN
  logic            overflow;
`endif

  edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .level    (level),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .pending  (pending)
`ifdef OVF_DETECT_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_log[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding event per channel, rotating priority starting after the last grant.
  bit m_prev[N];
  bit m_pend[N];
  int m_ptr;
  bit m_vld;
  int m_id;
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0;
      m_pend[i] = 0;
    end
    m_ptr = 0;
    m_vld = 0;
    m_id  = 0;
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit e[N];
    bit iss[N];
    int w;
    for (int i = 0; i < N; i++) begin
      e[i]   = level[i] && !m_prev[i];
      iss[i] = 0;
    end
    if (!m_vld || ev_ready) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        iss[w] = 1;
        m_vld  = 1;
        m_id   = w;
        m_ptr  = (w + 1) % N;
      end else begin
        m_vld = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (e[i] && m_pend[i] && !iss[i]) m_ovf = 1;
      if (e[i])        m_pend[i] = 1;
      else if (iss[i]) m_pend[i] = 0;
      m_prev[i] = level[i];
    end
  endtask

  function automatic int model_pend_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) m = m | (1 << i);
    return m;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Accepted-event log (handshakes seen at the clock edge).
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && ev_valid && ev_ready) acc_log.push_back(int'(ev_id));
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model ev_valid", int'(ev_valid), int'(m_vld));
      check("model ev_id", int'(ev_id), m_id);
      check("model pending", int'(pending), model_pend_mask());
`ifdef OVF_DETECT_EN
      check("model overflow", int'(overflow), int'(m_ovf));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    level    = '0;
    ev_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    acc_log.delete();
  endtask

  // exp holds expected ids as nibbles, first accepted in the most significant used nibble.
  task automatic check_seq(input string name, input int n, input logic [31:0] exp);
    check({name, " count"}, acc_log.size(), n);
    for (int k = 0; k < n && k < acc_log.size(); k++)
      check(name, acc_log[k], int'(exp[(n-1-k)*4 +: 4]));
  endtask

  initial begin
    step();
    check("reset ev_valid", int'(ev_valid), 0);
    check("reset pending", int'(pending), 0);
    check("reset ev_id", int'(ev_id), 0);
`ifdef OVF_DETECT_EN
    check("reset overflow", int'(overflow), 0);
`endif

    // Single edge on channel 1.
    do_reset();
    level = 4'b0010; ev_ready = 1'b1;
    step();
    check("single pend", int'(pending), 4'b0010);
    check("single early valid", int'(ev_valid), 0);
    step();
    check("single valid", int'(ev_valid), 1);
    check("single id", int'(ev_id), 1);
    check("single pend clr", int'(pending), 0);
    step();
    check("single valid drop", int'(ev_valid), 0);
    repeat (3) step();
    check_seq("single seq", 1, 32'h1);

    // Simultaneous edges on all channels.
    do_reset();
    level = 4'b1111; ev_ready = 1'b1;
    repeat (8) step();
    check_seq("simul seq", 4, 32'h0123);

    // Back-pressure.
    do_reset();
    level = 4'b0101; ev_ready = 1'b0;
    repeat (7) step();
    check("bp valid", int'(ev_valid), 1);
    check("bp id", int'(ev_id), 0);
    check("bp pend", int'(pending), 4'b0100);
    ev_ready = 1'b1;
    repeat (4) step();
    check_seq("bp seq", 2, 32'h02);

    // Round-robin wrap: grant 2 leaves rr_ptr at 3, then 3 beats 0.
    do_reset();
    level = 4'b0100; ev_ready = 1'b0;
    step();
    step();
    level = 4'b1101;
    step();
    check("wrap pend", int'(pending), 4'b1001);
    ev_ready = 1'b1;
    repeat (5) step();
    check_seq("wrap seq", 3, 32'h230);

    // Second edge on channel 1 lands on its issue cycle.
    do_reset();
    level = 4'b0011; ev_ready = 1'b0;
    step();
    level = 4'b0001;
    step();
    level = 4'b0011; ev_ready = 1'b1;
    step();
    check("sbc pend", int'(pending), 4'b0010);
    check("sbc id", int'(ev_id), 1);
`ifdef OVF_DETECT_EN
    check("sbc overflow", int'(overflow), 0);
`endif
    repeat (4) step();
    check_seq("sbc seq", 3, 32'h011);

    // Edge on a still-pending channel is merged.
    do_reset();
    level = 4'b0011; ev_ready = 1'b0;
    step();
    level = 4'b0001;
    step();
    level = 4'b0011;
    step();
`ifdef OVF_DETECT_EN
    check("merge overflow", int'(overflow), 1);
`endif
    ev_ready = 1'b1;
    repeat (5) step();
    check_seq("merge seq", 2, 32'h01);
`ifdef OVF_DETECT_EN
    check("overflow sticky", int'(overflow), 1);
`endif

    // Asynchronous reset mid-stream.
    do_reset();
    level = 4'b1111; ev_ready = 1'b0;
    step();
    step();
    check("midrst pend", int'(pending), 4'b1110);
    check("midrst valid", int'(ev_valid), 1);
    level = 4'b0001;
    #1 reset = 1'b1;
    #1;
    check("async rst valid", int'(ev_valid), 0);
    check("async rst pend", int'(pending), 0);
    step();
    step();
    reset = 1'b0;
    acc_log.delete();
    ev_ready = 1'b1;
    step();
    check("post rst pend", int'(pending), 4'b0001);
    step();
    check("post rst valid", int'(ev_valid), 1);
    check("post rst id", int'(ev_id), 0);
    repeat (3) step();
    check_seq("post rst seq", 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
